// File: rtl/cache_flush_walker_pkg.sv
// Shared cache package for the flush walker.
// Holds the walker FSM state encoding used by the top level.
package cache_flush_walker_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CHECK = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } flushstate_t;

endpackage

// File: rtl/cache_flush_walker_flush_counter.sv
// flush_counter: set/way position of the flush walk.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   i_Load        zero both counters (walk start)
//   i_Inc         step to the next way, wrapping into the next set
//   i_Skip        step to the next set with the way left at 0
//   o_FlushAdr    current set index
//   o_FlushWay    one-hot current way
//   o_LastWay     way counter is at NUMWAYS-1
//   o_LastSet     set counter is at NUMSETS-1
module flush_counter
  import cache_flush_walker_pkg::*;
#(
  parameter int unsigned NUMWAYS = 4,
  parameter int unsigned SETLEN  = 9,
  parameter int unsigned NUMSETS = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_Load,
  input  logic               i_Inc,
  input  logic               i_Skip,
  output logic [SETLEN-1:0]  o_FlushAdr,
  output logic [NUMWAYS-1:0] o_FlushWay,
  output logic               o_LastWay,
  output logic               o_LastSet
);

  localparam int unsigned WAYLEN = $clog2(NUMWAYS);
  localparam logic [WAYLEN-1:0] LASTWAY = WAYLEN'(NUMWAYS - 1);
  localparam logic [SETLEN-1:0] LASTSET = SETLEN'(NUMSETS - 1);

  logic [WAYLEN-1:0] r_way;
  logic [SETLEN-1:0] r_set;
  logic [SETLEN-1:0] w_set_next;

  assign o_LastWay  = (r_way == LASTWAY);
  // Compare against NUMSETS-1 rather than relying on overflow, so a
  // non-power-of-2 set count still terminates.
  assign o_LastSet  = (r_set == LASTSET);
  assign w_set_next = o_LastSet ? '0 : r_set + SETLEN'(1);
  assign o_FlushAdr = r_set;

  always_comb begin
    o_FlushWay        = '0;
    o_FlushWay[r_way] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || i_Load) begin
      r_way <= '0;
      r_set <= '0;
    end else if (i_Skip) begin
      r_way <= '0;
      r_set <= w_set_next;
    end else if (i_Inc) begin
      if (o_LastWay) begin
        r_way <= '0;
        r_set <= w_set_next;
      end else begin
        r_way <= r_way + WAYLEN'(1);
      end
    end
  end

endmodule

// File: rtl/cache_flush_walker.sv
// cache_flush_walker: walks every set/way of the cache on a flush request,
// writing back and cleaning each dirty line.
// Optional feature macro: FLUSH_SET_SKIP_EN -- when defined, a set whose dirty
// vector reads all-zero at way 0 is skipped as a whole.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   FlushReq      start a full flush (sampled in IDLE only)
//   FlushCancel   abort at the next safe point (after any writeback in flight)
//   DirtyWay      dirty bits of set FlushAdr, one cycle after it is presented
//   WbAck         writeback accepted
//   SelFlush      steer cache address mux to FlushAdr
//   FlushAdr      current set index
//   FlushWay      one-hot current way
//   WbReq         writeback request for (FlushAdr, FlushWay)
//   ClearDirty    clear dirty bit of (FlushAdr, FlushWay)
//   FlushBusy     high outside IDLE
//   FlushDone     one-cycle pulse at walk completion or cancel
module cache_flush_walker
  import cache_flush_walker_pkg::*;
#(
  parameter int unsigned NUMWAYS = 4,
  parameter int unsigned SETLEN  = 9,
  parameter int unsigned NUMSETS = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushReq,
  input  logic               FlushCancel,
  input  logic [NUMWAYS-1:0] DirtyWay,
  input  logic               WbAck,
  output logic               SelFlush,
  output logic [SETLEN-1:0]  FlushAdr,
  output logic [NUMWAYS-1:0] FlushWay,
  output logic               WbReq,
  output logic               ClearDirty,
  output logic               FlushBusy,
  output logic               FlushDone
);

  flushstate_t r_state;
  logic        r_cancel;
  logic        r_sel;
  logic        r_busy;
  logic        r_wbreq;
  logic        r_done;

  logic w_LastWay;
  logic w_LastSet;
  logic w_Dirty;
  logic w_CancelAny;
  logic w_SetClean;
  logic w_Load;
  logic w_AdvCheck;
  logic w_AdvWb;
  logic w_Skip;
  logic w_Inc;
  logic w_Final;

  always_comb begin
    w_Dirty     = |(DirtyWay & FlushWay);
    // A cancel arriving in the ack cycle itself must also end the walk.
    w_CancelAny = r_cancel | FlushCancel;
`ifdef FLUSH_SET_SKIP_EN
    w_SetClean  = FlushWay[0] & ~(|DirtyWay);
`else
    w_SetClean  = 1'b0;
`endif
    w_Load      = (r_state == IDLE) & FlushReq;
    w_AdvCheck  = (r_state == CHECK) & ~FlushCancel & ~w_Dirty;
    w_AdvWb     = (r_state == WB) & WbAck & ~w_CancelAny;
    w_Skip      = w_AdvCheck & w_SetClean;
    w_Inc       = (w_AdvCheck | w_AdvWb) & ~w_Skip;
    // Last position of the walk for whichever advance is taken this cycle.
    w_Final     = w_Skip ? w_LastSet : (w_LastWay & w_LastSet);
  end

  flush_counter #(
    .NUMWAYS(NUMWAYS),
    .SETLEN (SETLEN),
    .NUMSETS(NUMSETS)
  ) u_flush_counter (
    .clk       (clk),
    .reset     (reset),
    .i_Load    (w_Load),
    .i_Inc     (w_Inc),
    .i_Skip    (w_Skip),
    .o_FlushAdr(FlushAdr),
    .o_FlushWay(FlushWay),
    .o_LastWay (w_LastWay),
    .o_LastSet (w_LastSet)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cancel <= 1'b0;
      r_sel    <= 1'b0;
      r_busy   <= 1'b0;
      r_wbreq  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (FlushReq) begin
            r_state <= READ;
            r_busy  <= 1'b1;
            r_sel   <= 1'b1;
          end
        end
        READ: begin
          if (FlushCancel) begin
            r_state <= DONE;
            r_sel   <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (FlushCancel || (!w_Dirty && w_Final)) begin
            r_state <= DONE;
            r_sel   <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_Dirty) begin
            r_state <= WB;
            r_wbreq <= 1'b1;
          end else begin
            r_state <= READ;
          end
        end
        WB: begin
          // The request is never withdrawn before the ack; cancel waits here.
          if (WbAck) begin
            r_wbreq  <= 1'b0;
            r_cancel <= 1'b0;
            if (w_CancelAny || w_Final) begin
              r_state <= DONE;
              r_sel   <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= READ;
            end
          end else begin
            r_cancel <= w_CancelAny;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_cancel <= 1'b0;
          r_sel    <= 1'b0;
          r_busy   <= 1'b0;
          r_wbreq  <= 1'b0;
        end
      endcase
    end
  end

  assign SelFlush   = r_sel;
  assign FlushBusy  = r_busy;
  assign WbReq      = r_wbreq;
  assign FlushDone  = r_done;
  assign ClearDirty = r_wbreq & WbAck;

endmodule

// File: doc/cache_flush_walker.md
# cache_flush_walker

Sequencer that walks every set and way of a set-associative cache on a flush request. For each dirty line it issues a writeback handshake and then clears the line's dirty bit. It sits upstream of the cache arrays and the replacement-state block. It drives the flush address into the cache address-select mux, so the arrays and replacement state are read at that set while the flush runs.

## Interface
Parameters:
- NUMWAYS, 4, associativity; power of 2, ≥2
- SETLEN, 9, set index width
- NUMSETS, 128, number of sets; ≤ 2**SETLEN

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- FlushReq  in  1  start a full flush; sampled only in IDLE
- FlushCancel  in  1  abort the walk at the next safe point
- DirtyWay  in  NUMWAYS  dirty bits of the set read at FlushAdr; valid one cycle after FlushAdr is presented
- WbAck  in  1  writeback accepted by the bus side
- SelFlush  out  1  steers the cache address mux to FlushAdr
- FlushAdr  out  SETLEN  current set index
- FlushWay  out  NUMWAYS  one-hot current way
- WbReq  out  1  writeback request for the line (FlushAdr, FlushWay)
- ClearDirty  out  1  clear the dirty bit of (FlushAdr, FlushWay)
- FlushBusy  out  1  high in every state except IDLE
- FlushDone  out  1  one-cycle pulse when the walk completes or is cancelled

## Operation
States: IDLE, READ, CHECK, WB, DONE.
- IDLE
  - FlushReq → READ.
  - On entry to READ the set counter and way counter are both set to 0.
- READ
  - FlushAdr and FlushWay are presented; the arrays read synchronously.
  - Always → CHECK.
- CHECK
  - Tests DirtyWay against FlushWay.
  - Dirty → WB.
  - Clean → advance (below).
- WB
  - WbReq is held high with FlushAdr and FlushWay stable until WbAck.
  - ClearDirty = WbReq & WbAck.
  - In the ack cycle → advance.
- Advance
  - Way counter increments.
  - When the way counter is at NUMWAYS-1 it wraps to 0 and the set counter increments.
  - If the set counter was at NUMSETS-1 and the way counter at NUMWAYS-1 → DONE.
  - Otherwise → READ.
- DONE
  - FlushDone pulses for one cycle.
  - Always → IDLE.
- FlushCancel
  - From READ or CHECK: → DONE on the next edge.
  - In WB: the handshake completes first. Cancel is latched; on WbAck, ClearDirty fires and the state goes → DONE.
  - A WbReq is never dropped before WbAck.
- SelFlush = FlushBusy & ~DONE.
- FlushReq while busy is ignored. FlushReq in the DONE cycle is ignored.
- Counters are unsigned. The set counter compares against NUMSETS-1, so a non-power-of-2 NUMSETS terminates correctly.

## Timing
- Reset values:
  - state IDLE, counters 0
  - SelFlush, WbReq, ClearDirty, FlushBusy, FlushDone = 0
  - FlushAdr = 0, FlushWay = 0001
- Reset mid-walk: IDLE on the next edge. No FlushDone is emitted.
- FlushReq sampled at edge N: READ in cycle N+1, FlushBusy high from N+1.
- Clean line: 2 cycles (READ, CHECK).
- Dirty line: 2 + k cycles, where k ≥ 1 is the number of WB cycles up to and including the WbAck cycle.
- All-clean flush without macro: FlushDone in cycle N + 2·NUMSETS·NUMWAYS + 1.
- DirtyWay must be valid in CHECK, i.e. one cycle after READ. The walker does not register it.

## Configuration
- FLUSH_SET_SKIP_EN defined:
  - In CHECK with way counter = 0, if DirtyWay == 0, the walker skips the whole set.
  - The set counter increments, the way counter stays 0, and the state goes → READ (or → DONE on the last set).
  - All-clean flush: FlushDone at N + 2·NUMSETS + 1.
- Undefined: every way is visited individually, per Operation.

## Structure
- Shared cache package holds:
  - flushstate_t enum: IDLE, READ, CHECK, WB, DONE.
- One sub-module: flush_counter.
  - Set/way counters with load, increment, set-skip increment, and wrap.
  - Outputs LastWay, LastSet, and one-hot FlushWay.
- Top level holds the FSM, the cancel latch, and output logic.

## Test plan
- NUMWAYS=4, NUMSETS=4, all DirtyWay=0, FlushReq pulse → 16 READ/CHECK pairs, no WbReq, FlushDone at N+33 (N+9 with FLUSH_SET_SKIP_EN).
- Only set 2 way 3 dirty, WbAck 3 cycles after WbReq:
  - WbReq high exactly 3 cycles with FlushAdr=2, FlushWay=1000.
  - One ClearDirty pulse in the ack cycle.
  - FlushDone follows the last line.
- FlushCancel asserted in WB (set 1 way 0) with WbAck delayed 5 cycles → WbReq held until ack, ClearDirty pulses, then DONE. No further READ.
- FlushCancel in CHECK of set 0 way 1 (clean) → DONE next cycle, FlushDone one pulse, FlushBusy low after.
- Reset asserted mid-WB → all outputs at reset values next cycle, no FlushDone. A subsequent FlushReq restarts at set 0 way 0.
- FlushReq held high continuously → a new walk starts in the cycle after DONE (IDLE sample). No overlap, FlushDone once per walk.
